// File: rtl/mdio_master_ctrl_if.sv
// mdio_master_ctrl_if
//   Bundles the host command/response handshake and the MDIO pad signals of
//   the Clause-22 management master.
//
//   Host side : cmd_valid, cmd_ready, cmd_write, cmd_phy_addr, cmd_reg_addr,
//               cmd_wdata, rsp_valid, rsp_rdata, busy
//   PHY side  : mdc, mdio_out, mdio_oe, mdio_in
//
//   modport master : the controller (drives cmd_ready/rsp/busy and MDC/MDIO)
//   modport slave  : host + PHY environment facing the controller
interface mdio_master_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;
    logic        mdc;
    logic        mdio_out;
    logic        mdio_oe;
    logic        mdio_in;

    modport master (
        input  cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata, mdio_in,
        output cmd_ready, rsp_valid, rsp_rdata, busy, mdc, mdio_out, mdio_oe
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata, mdio_in,
        input  cmd_ready, rsp_valid, rsp_rdata, busy, mdc, mdio_out, mdio_oe
    );
endinterface

// File: rtl/mdio_master_ctrl.sv
// mdio_master_ctrl
//   Clause-22 MDIO management master. Each accepted host command is turned
//   into one complete frame: PREAMBLE_LEN ones, ST/OP/PHYAD/REGAD header,
//   turnaround and 16 data bits. MDC is derived from clk; read data is
//   sampled on MDC rising edges and returned with a one-cycle rsp_valid.
//
//   Parameters
//     CLK_DIV      : MDC half-period in clk cycles (2..255)
//     PREAMBLE_LEN : leading '1' bits per frame (1..32)
//
//   Ports
//     clk   : system clock, rising edge
//     reset : synchronous, active-high
//     bus   : mdio_master_ctrl_if.master (command/response + MDC/MDIO pads)
module mdio_master_ctrl #(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned PREAMBLE_LEN = 32
) (
    input  logic               clk,
    input  logic               reset,
    mdio_master_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [4:0] PRE_LAST  = 5'(PREAMBLE_LEN - 1);
    localparam logic [4:0] HDR_LAST  = 5'd13;
    localparam logic [4:0] TA_LAST   = 5'd1;
    localparam logic [4:0] DATA_LAST = 5'd15;

    state_t      r_state,     w_state_nxt;
    logic [7:0]  r_div,       w_div_nxt;
    logic        r_half,      w_half_nxt;     // 0 = MDC low half, 1 = high half
    logic        r_start,     w_start_nxt;    // first bit pending after acceptance
    logic [4:0]  r_bitcnt,    w_bitcnt_nxt;
    logic        r_write,     w_write_nxt;
    logic [31:0] r_tx,        w_tx_nxt;       // ST,OP,PHYAD,REGAD,TA,DATA
    logic [15:0] r_rx,        w_rx_nxt;
    logic [15:0] r_rdata,     w_rdata_nxt;
    logic        r_mdc,       w_mdc_nxt;
    logic        r_mdio_out,  w_mdio_out_nxt;
    logic        r_mdio_oe,   w_mdio_oe_nxt;
    logic        r_rsp_valid, w_rsp_valid_nxt;

    logic        w_ready;

    assign w_ready       = (r_state == S_IDLE);
    assign bus.cmd_ready = w_ready;
    assign bus.busy      = !w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.mdc       = r_mdc;
    assign bus.mdio_out  = r_mdio_out;
    assign bus.mdio_oe   = r_mdio_oe;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_half      <= 1'b0;
            r_start     <= 1'b0;
            r_bitcnt    <= '0;
            r_write     <= 1'b0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_rdata     <= '0;
            r_mdc       <= 1'b0;
            r_mdio_out  <= 1'b1;
            r_mdio_oe   <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div       <= w_div_nxt;
            r_half      <= w_half_nxt;
            r_start     <= w_start_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_write     <= w_write_nxt;
            r_tx        <= w_tx_nxt;
            r_rx        <= w_rx_nxt;
            r_rdata     <= w_rdata_nxt;
            r_mdc       <= w_mdc_nxt;
            r_mdio_out  <= w_mdio_out_nxt;
            r_mdio_oe   <= w_mdio_oe_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_div_nxt       = r_div;
        w_half_nxt      = r_half;
        w_start_nxt     = r_start;
        w_bitcnt_nxt    = r_bitcnt;
        w_write_nxt     = r_write;
        w_tx_nxt        = r_tx;
        w_rx_nxt        = r_rx;
        w_rdata_nxt     = r_rdata;
        w_mdc_nxt       = r_mdc;
        w_mdio_out_nxt  = r_mdio_out;
        w_mdio_oe_nxt   = r_mdio_oe;
        w_rsp_valid_nxt = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_mdc_nxt      = 1'b0;
                w_mdio_out_nxt = 1'b1;
                w_mdio_oe_nxt  = 1'b0;
                if (bus.cmd_valid) begin
                    w_state_nxt  = S_PRE;
                    w_bitcnt_nxt = PRE_LAST;
                    w_start_nxt  = 1'b1;
                    w_div_nxt    = '0;
                    w_half_nxt   = 1'b0;
                    w_write_nxt  = bus.cmd_write;
                    w_rx_nxt     = '0;
                    w_tx_nxt     = {2'b01,
                                    bus.cmd_write ? 2'b01 : 2'b10,
                                    bus.cmd_phy_addr,
                                    bus.cmd_reg_addr,
                                    2'b10,
                                    bus.cmd_write ? bus.cmd_wdata : 16'h0000};
                end
            end

            S_PRE, S_HDR, S_TA, S_DATA: begin
                if (r_start) begin
                    // Acceptance cycle is followed by the first bit period.
                    w_start_nxt    = 1'b0;
                    w_div_nxt      = '0;
                    w_half_nxt     = 1'b0;
                    w_mdc_nxt      = 1'b0;
                    w_mdio_out_nxt = 1'b1;
                    w_mdio_oe_nxt  = 1'b1;
                end else begin
                    w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + 8'd1;
                    if (r_div == DIV_LAST) begin
                        if (!r_half) begin
                            // MDC rising: PHY data is stable here.
                            w_half_nxt = 1'b1;
                            w_mdc_nxt  = 1'b1;
                            if (r_state == S_DATA) begin
                                w_rx_nxt = {r_rx[14:0], bus.mdio_in};
                            end
                        end else begin
                            // MDC falling: end of one bit, start of the next.
                            w_half_nxt = 1'b0;
                            w_mdc_nxt  = 1'b0;
                            if (r_state != S_PRE) begin
                                w_tx_nxt = {r_tx[30:0], 1'b0};
                            end
                            if (r_bitcnt != '0) begin
                                w_bitcnt_nxt = r_bitcnt - 5'd1;
                            end else begin
                                unique case (r_state)
                                    S_PRE: begin
                                        w_state_nxt  = S_HDR;
                                        w_bitcnt_nxt = HDR_LAST;
                                    end
                                    S_HDR: begin
                                        w_state_nxt  = S_TA;
                                        w_bitcnt_nxt = TA_LAST;
                                    end
                                    S_TA: begin
                                        w_state_nxt  = S_DATA;
                                        w_bitcnt_nxt = DATA_LAST;
                                    end
                                    default: begin
                                        w_state_nxt     = S_DONE;
                                        w_rsp_valid_nxt = 1'b1;
                                        if (!r_write) begin
                                            w_rdata_nxt = r_rx;
                                        end
                                    end
                                endcase
                            end

                            // Drive the bit that starts now.
                            unique case (w_state_nxt)
                                S_PRE: begin
                                    w_mdio_out_nxt = 1'b1;
                                    w_mdio_oe_nxt  = 1'b1;
                                end
                                S_HDR: begin
                                    w_mdio_out_nxt = w_tx_nxt[31];
                                    w_mdio_oe_nxt  = 1'b1;
                                end
                                S_TA, S_DATA: begin
                                    // Reads release the line from turnaround on.
                                    w_mdio_out_nxt = r_write ? w_tx_nxt[31] : 1'b1;
                                    w_mdio_oe_nxt  = r_write;
                                end
                                default: begin
                                    w_mdio_out_nxt = 1'b1;
                                    w_mdio_oe_nxt  = 1'b0;
                                end
                            endcase
                        end
                    end
                end
            end

            S_DONE: begin
                w_state_nxt    = S_IDLE;
                w_mdc_nxt      = 1'b0;
                w_mdio_out_nxt = 1'b1;
                w_mdio_oe_nxt  = 1'b0;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// tb_mdio_master_ctrl
//   Directed bench for mdio_master_ctrl. u_dut uses the default parameters
//   with a bit-capturing monitor and a PHY read-data model; u_dut2 uses
//   CLK_DIV=2 for MDC timing and latency.
module tb_mdio_master_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdio_master_ctrl_if bus ();
    mdio_master_ctrl_if bus2 ();

    mdio_master_ctrl #(.CLK_DIV(4), .PREAMBLE_LEN(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mdio_master_ctrl #(.CLK_DIV(2), .PREAMBLE_LEN(32)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor + PHY model for u_dut ----------------
    logic        cap_out [0:1023];
    logic        cap_oe  [0:1023];
    int unsigned cap_cyc [0:1023];
    int unsigned rise_cnt = 0;
    logic        prev_mdc = 1'b0;
    int unsigned acc_cnt = 0, acc_edge = 0, rsp_cnt = 0, lat = 0;
    int unsigned acc_hist [0:15];
    int unsigned rsp_hist [0:15];
    logic [15:0] rsp_seen = '0;
    logic        done_mdc, done_oe, done_out;
    logic        slave_en = 1'b0;
    logic [15:0] slave_data = '0;
    int unsigned slave_base = 0;
    int unsigned idx;

    always @(negedge clk) begin
        if (!slave_en) bus.mdio_in = 1'b1;
        if (bus.mdc && !prev_mdc) begin
            if (rise_cnt < 1024) begin
                cap_out[10'(rise_cnt)] = bus.mdio_out;
                cap_oe[10'(rise_cnt)]  = bus.mdio_oe;
                cap_cyc[10'(rise_cnt)] = cyc;
            end
            rise_cnt++;
        end
        if (!bus.mdc && prev_mdc && slave_en) begin
            idx = rise_cnt - slave_base;
            if (idx >= 48 && idx < 64) bus.mdio_in = slave_data[4'(63 - idx)];
            else bus.mdio_in = 1'b1;
        end
        prev_mdc = bus.mdc;
        if (bus.cmd_valid && bus.cmd_ready && !reset) begin
            acc_edge = cyc + 1;
            acc_hist[4'(acc_cnt)] = cyc + 1;
            acc_cnt++;
        end
        if (bus.rsp_valid) begin
            lat      = cyc - acc_edge;
            rsp_seen = bus.rsp_rdata;
            done_mdc = bus.mdc;
            done_oe  = bus.mdio_oe;
            done_out = bus.mdio_out;
            rsp_hist[4'(rsp_cnt)] = cyc;
            rsp_cnt++;
        end
    end

    // ---------------- monitor for u_dut2 ----------------
    logic        prev2 = 1'b0;
    int unsigned rise2_cnt = 0, last_rise2 = 0, last_fall2 = 0;
    int unsigned per2 = 0, lo2 = 0, hi2 = 0;
    int unsigned acc2_cnt = 0, acc2_edge = 0, rsp2_cnt = 0, lat2 = 0;

    always @(negedge clk) begin
        bus2.mdio_in = 1'b1;
        if (bus2.mdc && !prev2) begin
            if (rise2_cnt == 10) begin
                per2 = cyc - last_rise2;
                lo2  = cyc - last_fall2;
            end
            last_rise2 = cyc;
            rise2_cnt++;
        end
        if (!bus2.mdc && prev2) begin
            if (rise2_cnt == 11) hi2 = cyc - last_rise2;
            last_fall2 = cyc;
        end
        prev2 = bus2.mdc;
        if (bus2.cmd_valid && bus2.cmd_ready && !reset) begin
            acc2_edge = cyc + 1;
            acc2_cnt++;
        end
        if (bus2.rsp_valid) begin
            lat2 = cyc - acc2_edge;
            rsp2_cnt++;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack(input int unsigned base, input int unsigned n);
        logic [31:0] v = '0;
        for (int unsigned i = 0; i < n; i++) v = {v[30:0], cap_out[10'(base + i)]};
        return v;
    endfunction

    function automatic logic [31:0] count_oe(input int unsigned base, input int unsigned n);
        logic [31:0] c = '0;
        for (int unsigned i = 0; i < n; i++) if (cap_oe[10'(base + i)] === 1'b1) c++;
        return c;
    endfunction

    task automatic set_cmd(input logic wr, input logic [4:0] phy, input logic [4:0] ra,
                           input logic [15:0] wd);
        bus.cmd_write    = wr;
        bus.cmd_phy_addr = phy;
        bus.cmd_reg_addr = ra;
        bus.cmd_wdata    = wd;
        bus.cmd_valid    = 1'b1;
    endtask

    task automatic issue(input string tag, input logic wr, input logic [4:0] phy,
                         input logic [4:0] ra, input logic [15:0] wd);
        int unsigned a0;
        a0 = acc_cnt;
        set_cmd(wr, phy, ra, wd);
        for (int i = 0; i < 2000 && acc_cnt == a0; i++) tick();
        bus.cmd_valid = 1'b0;
        check({tag, "_accept"}, acc_cnt - a0, 1);
    endtask

    task automatic wait_rsp(input string tag, input int unsigned r0);
        for (int i = 0; i < 2000 && rsp_cnt == r0; i++) tick();
        check({tag, "_rsp"}, rsp_cnt - r0, 1);
    endtask

    int unsigned b, r0, a0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time limit, expected completion");
        $fatal(1);
    end

    initial begin
        reset             = 1'b1;
        bus2.cmd_valid    = 1'b0;
        bus2.cmd_write    = 1'b1;
        bus2.cmd_phy_addr = '0;
        bus2.cmd_reg_addr = '0;
        bus2.cmd_wdata    = '0;
        // Command held during reset must be ignored.
        set_cmd(1'b1, 5'h01, 5'h02, 16'hA5C3);
        repeat (4) tick();
        check("rst_ready", 32'(bus.cmd_ready), 1);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_mdc", 32'(bus.mdc), 0);
        check("rst_mdio_out", 32'(bus.mdio_out), 1);
        check("rst_mdio_oe", 32'(bus.mdio_oe), 0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rdata", 32'(bus.rsp_rdata), 0);
        bus.cmd_valid = 1'b0;
        reset = 1'b0;
        repeat (3) tick();
        check("post_rst_idle", 32'(bus.cmd_ready), 1);

        // Write 0x01/0x02 <- 0xA5C3
        b = rise_cnt; r0 = rsp_cnt;
        issue("wr1", 1'b1, 5'h01, 5'h02, 16'hA5C3);
        wait_rsp("wr1", r0);
        check("wr1_latency", lat, 513);
        check("wr1_bits", rise_cnt - b, 64);
        check("wr1_preamble", pack(b, 32), 32'hFFFF_FFFF);
        check("wr1_body", pack(b + 32, 32), 32'h508A_A5C3);
        check("wr1_oe", count_oe(b, 64), 64);
        check("wr1_rdata_kept", 32'(rsp_seen), 0);
        check("wr1_done_mdc", 32'(done_mdc), 0);
        check("wr1_done_oe", 32'(done_oe), 0);
        check("wr1_done_out", 32'(done_out), 1);
        check("wr1_pulse_end", 32'(bus.rsp_valid), 0);
        check("wr1_ready", 32'(bus.cmd_ready), 1);

        // Read 0x1F/0x00, PHY returns 0xBEEF
        b = rise_cnt; r0 = rsp_cnt;
        slave_data = 16'hBEEF; slave_base = rise_cnt; slave_en = 1'b1;
        issue("rd1", 1'b0, 5'h1F, 5'h00, 16'h1234);
        wait_rsp("rd1", r0);
        slave_en = 1'b0;
        check("rd1_latency", lat, 513);
        check("rd1_header", pack(b + 32, 14), 32'h0000_1BE0);
        check("rd1_oe_driven", count_oe(b, 46), 46);
        check("rd1_oe_released", count_oe(b + 46, 18), 0);
        check("rd1_rdata_pulse", 32'(rsp_seen), 32'h0000_BEEF);
        check("rd1_rdata_hold", 32'(bus.rsp_rdata), 32'h0000_BEEF);

        // Two writes held valid back-to-back
        b = rise_cnt; r0 = rsp_cnt; a0 = acc_cnt;
        set_cmd(1'b1, 5'h03, 5'h04, 16'h1234);
        for (int i = 0; i < 2000 && acc_cnt == a0; i++) tick();
        set_cmd(1'b1, 5'h15, 5'h1A, 16'hF00D);
        for (int i = 0; i < 2000 && acc_cnt == a0 + 1; i++) tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 2000 && rsp_cnt < r0 + 2; i++) tick();
        check("b2b_rsp_count", rsp_cnt - r0, 2);
        check("b2b_accept_gap", acc_hist[4'(a0 + 1)] - rsp_hist[4'(r0)], 2);
        check("b2b_mdc_gap", cap_cyc[10'(b + 64)] - cap_cyc[10'(b + 63)], 11);
        check("b2b_body_a", pack(b + 32, 32), 32'h5192_1234);
        check("b2b_preamble_b", pack(b + 64, 32), 32'hFFFF_FFFF);
        check("b2b_body_b", pack(b + 96, 32), 32'h5AEA_F00D);
        check("b2b_latency_b", lat, 513);
        check("b2b_rdata_kept", 32'(bus.rsp_rdata), 32'h0000_BEEF);

        // Command pulsed mid-frame is ignored
        b = rise_cnt; r0 = rsp_cnt; a0 = acc_cnt;
        issue("mid", 1'b1, 5'h0A, 5'h05, 16'h0F0F);
        repeat (100) tick();
        set_cmd(1'b0, 5'h1F, 5'h1F, 16'hFFFF);
        repeat (3) tick();
        bus.cmd_valid = 1'b0;
        wait_rsp("mid", r0);
        repeat (600) tick();
        check("mid_one_rsp", rsp_cnt - r0, 1);
        check("mid_one_accept", acc_cnt - a0, 1);
        check("mid_body", pack(b + 32, 32), 32'h5516_0F0F);
        check("mid_oe", count_oe(b, 64), 64);

        // Reset during DATA of a read aborts the frame
        b = rise_cnt; r0 = rsp_cnt;
        slave_data = 16'h1357; slave_base = rise_cnt; slave_en = 1'b1;
        issue("abort", 1'b0, 5'h02, 5'h03, 16'h0000);
        for (int i = 0; i < 2000 && (rise_cnt - b) < 52; i++) tick();
        check("abort_in_data", 32'((rise_cnt - b) >= 52), 1);
        reset = 1'b1;
        tick();
        check("abort_mdc", 32'(bus.mdc), 0);
        check("abort_oe", 32'(bus.mdio_oe), 0);
        check("abort_out", 32'(bus.mdio_out), 1);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 0);
        check("abort_rdata", 32'(bus.rsp_rdata), 0);
        check("abort_ready", 32'(bus.cmd_ready), 1);
        reset = 1'b0;
        slave_en = 1'b0;
        repeat (600) tick();
        check("abort_no_rsp", rsp_cnt - r0, 0);

        b = rise_cnt; r0 = rsp_cnt;
        issue("wr2", 1'b1, 5'h01, 5'h02, 16'hA5C3);
        wait_rsp("wr2", r0);
        check("wr2_latency", lat, 513);
        check("wr2_body", pack(b + 32, 32), 32'h508A_A5C3);
        check("wr2_rdata", 32'(rsp_seen), 0);

        // CLK_DIV = 2 instance
        bus2.cmd_write    = 1'b1;
        bus2.cmd_phy_addr = 5'h07;
        bus2.cmd_reg_addr = 5'h09;
        bus2.cmd_wdata    = 16'h5A5A;
        bus2.cmd_valid    = 1'b1;
        for (int i = 0; i < 2000 && acc2_cnt == 0; i++) tick();
        bus2.cmd_valid = 1'b0;
        check("div2_accept", acc2_cnt, 1);
        for (int i = 0; i < 2000 && rsp2_cnt == 0; i++) tick();
        check("div2_rsp", rsp2_cnt, 1);
        check("div2_latency", lat2, 257);
        check("div2_period", per2, 4);
        check("div2_low", lo2, 2);
        check("div2_high", hi2, 2);
        check("div2_bits", rise2_cnt, 64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdio_master_ctrl.md
Name: mdio_master_ctrl

Overview:
- Clause-22 MDIO management master. Accepts read/write commands from a host-side register interface and serializes each into a complete management frame on MDC/MDIO.
- Generates MDC from `clk` and controls the MDIO tri-state direction.
- Returns read data to the host.
- Sits between the system register bus and the MDIO peripheral (PHY side), and sequences every access to it.

Parameters:
- CLK_DIV, 4, MDC half-period in `clk` cycles. Legal range is 2..255.
- PREAMBLE_LEN, 32, number of leading '1' bits per frame. Legal range is 1..32.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  host command strobe.
- cmd_ready  output  1  controller idle and able to accept a command.
- cmd_write  input  1  1 = write frame, 0 = read frame.
- cmd_phy_addr  input  5  PHYAD field.
- cmd_reg_addr  input  5  REGAD field.
- cmd_wdata  input  16  write data; ignored for reads.
- rsp_valid  output  1  one-cycle pulse when a frame completes.
- rsp_rdata  output  16  read data captured by the last read frame.
- busy  output  1  frame in progress.
- mdc  output  1  management clock.
- mdio_out  output  1  MDIO drive value.
- mdio_oe  output  1  1 = master drives MDIO.
- mdio_in  input  1  sampled MDIO pad value.

Behaviour:
- Reset, synchronous while `reset`=1:
  - state=IDLE, mdc=0, mdio_out=1, mdio_oe=0, rsp_valid=0, rsp_rdata=0, busy=0, cmd_ready=1.
  - Commands presented while `reset`=1 are ignored.
  - A reset mid-frame aborts the frame immediately; no rsp_valid is produced.
- Handshake:
  - A command is accepted on the edge where cmd_valid && cmd_ready.
  - All command fields are latched on that edge.
  - cmd_ready = (state==IDLE); busy = !cmd_ready.
  - cmd_valid while busy has no effect.
- States: IDLE -> PRE -> HDR -> TA -> DATA -> DONE -> IDLE.
  - PRE: PREAMBLE_LEN bits of '1'.
  - HDR: 14 bits, sent MSB-first: ST=01, OP (write 01, read 10), PHYAD[4:0], REGAD[4:0].
  - TA: 2 bits. Write drives 1 then 0. Read sets mdio_oe=0 for both bits.
  - DATA: 16 bits, MSB-first.
  - DONE: one cycle; rsp_valid=1 for that cycle; then IDLE.
- Bit timing:
  - Each bit period is 2*CLK_DIV cycles: mdc low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - mdio_out/mdio_oe change only on the cycle mdc goes low, i.e. the bit-period start. The first bit starts the cycle after acceptance.
  - Read data is sampled from mdio_in on the cycle mdc goes high and shifted into a 16-bit register.
  - rsp_rdata updates in DONE of read frames only. Write frames leave rsp_rdata unchanged.
  - In read frames, mdio_oe=0 from the first TA bit until the frame ends.
- Latency: with N = PREAMBLE_LEN + 32 bits, rsp_valid is high exactly (N*2*CLK_DIV)+1 cycles after the acceptance edge. With defaults this is 513 cycles.
- End of frame: mdc returns to 0. mdio_oe=0 and mdio_out=1 from DONE onward.
- Back-to-back commands: cmd_ready=1 the cycle after DONE. A new frame can start immediately, and its preamble begins one cycle later.
- Counters:
  - MDC divider counts 0..CLK_DIV-1 and wraps.
  - Bit counter counts down to zero per state, then loads the next state's length.
  - There is no overflow at parameter maxima.

Test Plan:
- Write, defaults, phy=0x01, reg=0x02, wdata=0xA5C3 -> 32 ones, then `0101 00001 00010 10 1010010111000011` sampled at mdc rising edges. mdio_oe=1 throughout. rsp_valid at cycle 513 after acceptance. rsp_rdata is unchanged.
- Read, phy=0x1F, reg=0x00, slave model drives 0xBEEF on falling edges after TA -> header `0110 11111 00000`. mdio_oe=0 during TA and DATA. rsp_rdata=0xBEEF with the rsp_valid pulse.
- CLK_DIV=2 -> mdc period is exactly 4 clk cycles with a 50% duty cycle. rsp_valid at 257 cycles after acceptance.
- Two commands held valid back-to-back -> second accepted the cycle after the first rsp_valid. No gap in mdc beyond the one-cycle DONE plus idle cycle. Both frames are bit-correct.
- cmd_valid pulsed with different fields mid-frame -> ignored; the in-flight frame is unaltered and only one rsp_valid is produced.
- Reset asserted in DATA of a read -> next cycle mdc=0, mdio_oe=0, mdio_out=1, rsp_valid=0, rsp_rdata=0, cmd_ready=1. A subsequent write completes normally.
